fft_reorder: RTL and testbench
==============================

# fft_reorder

Output reorder stage placed directly downstream of the `fft` top. It accepts the serial 34-bit complex sample stream produced by `p_s`, which arrives in bit-reversed index order, one sample per valid cycle. It writes each frame into one bank of a ping-pong buffer at the bit-reversed address and streams the previous frame out in natural index order. The output side has a valid/ready handshake so the downstream consumer can stall without disturbing the FFT core, which has no backpressure.

## Interface
Parameters:
- `N_POINTS`, default 16: frame length; must be a power of two, at least 4.
- `DATA_W`, default 34: sample width; `[33:17]` is real, `[16:0]` is imaginary, both two's complement. The block passes samples through opaquely.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-high reset. The port keeps the codebase name, but asserting it high resets the block.
- `in_valid` input 1: `in_data` carries a sample this cycle.
- `in_data` input DATA_W: sample from the FFT core, in bit-reversed order within the frame.
- `in_ready` output 1: a write bank is available. This is informational, because the FFT cannot stall.
- `out_valid` output 1: `out_data` holds a valid sample.
- `out_ready` input 1: the consumer accepts the sample when this is high together with `out_valid`.
- `out_data` output DATA_W: sample in natural order.
- `out_sop` output 1: marks sample index 0 of a frame; valid only with `out_valid`.
- `out_eop` output 1: marks sample index N_POINTS-1 of a frame; valid only with `out_valid`.
- `overflow` output 1: sticky flag, set when a sample is dropped; cleared only by reset.

## Operation
- **Banks:** two banks, A and B, each N_POINTS x DATA_W. Each bank holds a state: EMPTY, FILLING, FULL or DRAINING.
- **Write side:**
  - Holds a write-bank pointer `wb` and a write counter `wc` of LOG2N bits.
  - On `in_valid` with bank `wb` in EMPTY or FILLING: store `in_data` at `bitrev(wc)` and increment `wc`. A write to an EMPTY bank moves it to FILLING.
  - When `wc == N_POINTS-1`: the bank goes to FULL, `wc` wraps to 0, and `wb` toggles.
- **Drop rule:** on `in_valid` when bank `wb` is FULL or DRAINING, drop the sample, set `overflow`, and leave `wc` unchanged.
- **`in_ready`:** equals 1 when bank `wb` is EMPTY or FILLING.
- **Read side:**
  - Holds a read-bank pointer `rb` and a read counter `rc`.
  - When bank `rb` is FULL, it moves to DRAINING and reads proceed at natural address `rc`.
  - The output register loads when `!out_valid || out_ready`.
  - After the sample at `rc == N_POINTS-1` is loaded: the bank goes to EMPTY, `rc` wraps to 0, and `rb` toggles.
- **Frame order:** frames leave in arrival order, A, B, A, and so on. `wb` and `rb` both reset to A.
- **Flags:** `out_sop` is asserted when the loaded sample came from `rc == 0`. `out_eop` is asserted when it came from `rc == N_POINTS-1`.
- **Same-bank events:** when the read side frees a bank in the same cycle the write side would drop a sample into it, the write is still dropped. The bank-state update happens at the end of the cycle, and `in_ready` is registered-state based.
- **Reset:** asynchronous, active-high, mid-operation.
  - Both banks go to EMPTY and all counters and pointers go to 0.
  - `out_valid`, `out_sop`, `out_eop` and `overflow` go to 0, and `out_data` goes to 0.
  - Reset does not clear RAM contents.
  - Any partial frame is discarded.

## Timing
- **Write-to-read latency:** if the last sample of a frame is written at cycle t, the first output sample appears with `out_valid=1` at cycle t+2. That covers the bank state update at t+1 and the registered read at t+2.
- **Throughput:** with `out_ready` held high, there is one output per cycle and no bubbles between back-to-back frames. This holds when the next bank is FULL before the current drain ends.
- **Output stability:** `out_data`, `out_sop` and `out_eop` hold steady while `out_valid && !out_ready`.
- **Write latency:** zero-cycle capture; no input-side pipeline.
- **Reset values:** `in_ready` is 1 out of reset. All other outputs are 0.

## Structure
- **Package `fft_pkg`:**
  - `DATA_W`, `N_POINTS`, `LOG2N = $clog2(N_POINTS)`.
  - The bank-state enum {EMPTY, FILLING, FULL, DRAINING}.
  - A `bitrev(idx)` function over LOG2N bits.
- **Sub-module `reorder_bank`:** a simple dual-port RAM with one write port and one registered read port, N_POINTS x DATA_W. It is instantiated twice.
- **`fft_reorder` top:** holds the write/read control, bank-state registers and output register.

## Test plan
- **Single frame, natural reorder:** drive N=16 samples with values 0..15 in arrival order, `out_ready=1`. Output must be 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. `out_sop` must be set on the first sample, `out_eop` on the last, and the first `out_valid` must come 2 cycles after the last input.
- **Back-to-back frames:** drive 3 consecutive frames with base offsets 0x000, 0x100, 0x200. Expect 48 outputs with no bubbles after the first, in frame order, `overflow=0`.
- **Output stall:** hold `out_ready=0` for 5 cycles mid-frame at output index 6. `out_data` must stay at value 6 of the reordered sequence (value 6) with `out_valid=1`; the stream then resumes with no loss or duplication.
- **Overflow:** hold `out_ready=0` and send 3 full frames. Frames 1 and 2 are stored and frame 3 is dropped: `overflow` rises on the first sample of frame 3 and `in_ready=0`. Then release `out_ready`: exactly 32 outputs must come out, from frames 1 and 2.
- **Reset mid-frame:** assert `rst_n` high after 7 input samples. All outputs must go to reset values immediately. After release, a fresh 16-sample frame must reorder correctly, with no leftover samples emitted.
- **Gapped input:** send `in_valid` with random gaps, about 50% duty, for one frame. The output sequence must be identical to the single-frame case.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, bank-state encoding and index helper for the FFT output reorder stage.
package fft_pkg;

  localparam int unsigned DATA_W   = 34;
  localparam int unsigned N_POINTS = 16;
  localparam int unsigned LOG2N    = $clog2(N_POINTS);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Mirror the LOG2N-bit index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = idx[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One ping-pong bank: single write port, registered read port whose output holds when not read.
module reorder_bank #(
  parameter int unsigned DEPTH = fft_pkg::N_POINTS,
  parameter int unsigned WIDTH = fft_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Storage array is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder stage: ping-pong banks written at bitrev(wc),
// drained in natural order through a valid/ready output whose data register is the bank read port.
module fft_reorder #(
  parameter int unsigned N_POINTS = fft_pkg::N_POINTS,
  parameter int unsigned DATA_W   = fft_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              overflow
);

  import fft_pkg::*;

  localparam int unsigned   AW   = $clog2(N_POINTS);
  localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic          wb_q, wb_d, rb_q, rb_d, sel_q, sel_d;
  logic [AW-1:0] wc_q, wc_d, rc_q, rc_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          sop_q, sop_d, eop_q, eop_d;
  logic          overflow_q, overflow_d;

  logic                   wr_ok_c, rd_avail_c, load_c;
  logic [1:0]             wr_en_c, rd_en_c;
  logic [AW-1:0]          wr_addr_c;
  logic [1:0][DATA_W-1:0] rd_data_c;

  // Write and read sides only ever touch disjoint bank states, so both updates apply in one pass.
  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    sel_d       = sel_q;
    wc_d        = wc_q;
    rc_d        = rc_q;
    out_valid_d = out_valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    overflow_d  = overflow_q;
    wr_en_c     = '0;
    rd_en_c     = '0;
    wr_addr_c   = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      wr_addr_c[i] = wc_q[AW-1-i];
    end

    wr_ok_c    = state_q[wb_q] inside {EMPTY, FILLING};
    rd_avail_c = state_q[rb_q] inside {FULL, DRAINING};
    load_c     = !out_valid_q || out_ready;

    if (in_valid) begin
      if (wr_ok_c) begin
        wr_en_c[wb_q] = 1'b1;
        wc_d          = wc_q + AW'(1);
        state_d[wb_q] = FILLING;
        if (wc_q == LAST) begin
          state_d[wb_q] = FULL;
          wc_d          = '0;
          wb_d          = ~wb_q;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (load_c) begin
      if (rd_avail_c) begin
        rd_en_c[rb_q] = 1'b1;
        out_valid_d   = 1'b1;
        sop_d         = (rc_q == '0);
        eop_d         = (rc_q == LAST);
        sel_d         = rb_q;
        rc_d          = rc_q + AW'(1);
        state_d[rb_q] = DRAINING;
        if (rc_q == LAST) begin
          state_d[rb_q] = EMPTY;
          rc_d          = '0;
          rb_d          = ~rb_q;
        end
      end else begin
        out_valid_d = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
      end
    end

    in_ready_d = state_d[wb_d] inside {EMPTY, FILLING};
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      sel_q       <= 1'b0;
      wc_q        <= '0;
      rc_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      sel_q       <= sel_d;
      wc_q        <= wc_d;
      rc_q        <= rc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      overflow_q  <= overflow_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(
      .DEPTH (N_POINTS),
      .WIDTH (DATA_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst_n),
      .wr_en   (wr_en_c[b]),
      .wr_addr (wr_addr_c),
      .wr_data (in_data),
      .rd_en   (rd_en_c[b]),
      .rd_addr (rc_q),
      .rd_data (rd_data_c[b])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = rd_data_c[sel_q];
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Directed self-checking bench for fft_reorder: reorder, back-to-back, stall, overflow, reset, gapped input.
`timescale 1ns/1ps
module tb_fft_reorder;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 34;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          overflow;

  fft_reorder #(.N_POINTS(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned exp_order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  int checks = 0;
  int errors = 0;

  int            ncyc = 0;
  int            last_in_n = 0;
  logic [DW-1:0] q_data [$];
  logic          q_sop [$];
  logic          q_eop [$];
  int            q_cyc [$];

  // Accepted-output log, sampled mid-cycle.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (!rst_n) begin
      if (in_valid) last_in_n = ncyc;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_sop.push_back(out_sop);
        q_eop.push_back(out_eop);
        q_cyc.push_back(ncyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit gaps);
    for (int i = 0; i < int'(N); i++) begin
      if (gaps) idle(int'($urandom_range(0, 2)));
      put(base + DW'(i));
    end
  endtask

  task automatic wait_count(input int base, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while ((q_data.size() - base) < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_eq(tag, 64'((q_data.size() - base) >= n), 64'd1);
  endtask

  task automatic check_frame(input int base, input logic [DW-1:0] off, input string tag);
    int bad_flags;
    bad_flags = 0;
    for (int j = 0; j < int'(N); j++) begin
      if (base + j < q_data.size()) begin
        check_eq($sformatf("%s_d%0d", tag, j), 64'(q_data[base+j]), 64'(off) + 64'(exp_order[j]));
        if (q_sop[base+j] !== (j == 0)) bad_flags++;
        if (q_eop[base+j] !== (j == int'(N) - 1)) bad_flags++;
      end else begin
        bad_flags++;
      end
    end
    check_eq({tag, "_flags"}, 64'(bad_flags), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_out_data"},  64'(out_data),  64'd0);
    check_eq({tag, "_out_sop"},   64'(out_sop),   64'd0);
    check_eq({tag, "_out_eop"},   64'(out_eop),   64'd0);
    check_eq({tag, "_overflow"},  64'(overflow),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at ncyc=%0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int b2;
    int bubbles;
    bit found;

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    #10;
    check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b0;

    // Single frame, natural reorder and write-to-read latency.
    b = q_data.size();
    send_frame('0, 1'b0);
    idle(1);
    wait_count(b, 16, 60, "t1_count");
    check_frame(b, '0, "t1");
    check_eq("t1_latency", 64'((q_data.size() > b) ? q_cyc[b] - last_in_n : -1), 64'd2);
    check_eq("t1_contig", 64'((q_data.size() >= b + 16) ? q_cyc[b+15] - q_cyc[b] : -1), 64'd15);

    // Back-to-back frames with no output bubbles.
    idle(4);
    b = q_data.size();
    send_frame(DW'('h000), 1'b0);
    send_frame(DW'('h100), 1'b0);
    send_frame(DW'('h200), 1'b0);
    idle(1);
    wait_count(b, 48, 120, "t2_count");
    check_frame(b,      DW'('h000), "t2_f0");
    check_frame(b + 16, DW'('h100), "t2_f1");
    check_frame(b + 32, DW'('h200), "t2_f2");
    bubbles = 0;
    for (int i = 0; i < 47; i++) begin
      if (b + i + 1 < q_cyc.size() && q_cyc[b+i+1] - q_cyc[b+i] != 1) bubbles++;
    end
    check_eq("t2_bubbles", 64'(bubbles), 64'd0);
    check_eq("t2_overflow", 64'(overflow), 64'd0);

    // Output stall at index 6.
    idle(4);
    b = q_data.size();
    send_frame('0, 1'b0);
    idle(1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_data == DW'(6)) begin
        found = 1'b1;
        out_ready = 1'b0;
      end
    end
    check_eq("t3_found", 64'(found), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check_eq("t3_hold_valid", 64'(out_valid), 64'd1);
      check_eq("t3_hold_data",  64'(out_data),  64'd6);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_count(b, 16, 60, "t3_count");
    idle(4);
    check_eq("t3_total", 64'(q_data.size() - b), 64'd16);
    check_frame(b, '0, "t3");

    // Overflow: third frame dropped while the consumer is stalled.
    @(posedge clk); #1 out_ready = 1'b0;
    b = q_data.size();
    send_frame(DW'('h000), 1'b0);
    send_frame(DW'('h100), 1'b0);
    put(DW'('h200));
    check_eq("t4_in_ready_low", 64'(in_ready), 64'd0);
    check_eq("t4_ovf_before",   64'(overflow), 64'd0);
    put(DW'('h201));
    check_eq("t4_ovf_rise",     64'(overflow), 64'd1);
    for (int i = 2; i < int'(N); i++) put(DW'('h200) + DW'(i));
    idle(1);
    check_eq("t4_none_while_stalled", 64'(q_data.size() - b), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (80) @(posedge clk);
    check_eq("t4_total", 64'(q_data.size() - b), 64'd32);
    check_frame(b,      DW'('h000), "t4_f0");
    check_frame(b + 16, DW'('h100), "t4_f1");
    check_eq("t4_ovf_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a frame.
    b = q_data.size();
    for (int i = 0; i < 7; i++) put(DW'('h300) + DW'(i));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(posedge clk); #1 rst_n = 1'b0;
    check_eq("t5_no_partial", 64'(q_data.size() - b), 64'd0);
    b2 = q_data.size();
    send_frame(DW'('h300), 1'b0);
    idle(1);
    wait_count(b2, 16, 60, "t5_count");
    repeat (20) @(posedge clk);
    check_eq("t5_total", 64'(q_data.size() - b2), 64'd16);
    check_frame(b2, DW'('h300), "t5");

    // Gapped input gives the same sequence as the single-frame case.
    b = q_data.size();
    send_frame('0, 1'b1);
    idle(1);
    wait_count(b, 16, 80, "t6_count");
    check_frame(b, '0, "t6");
    check_eq("t6_latency", 64'((q_data.size() > b) ? q_cyc[b] - last_in_n : -1), 64'd2);
    check_eq("t6_overflow", 64'(overflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
